// File: rtl/comp_seq_if.sv
// comp_seq_if -- ready/valid handshake bundle for comp_seq.
//   in_valid / in_ready / in_data    : upstream word into the sequencer
//   out_valid / out_ready / out_data : two's-complement result to downstream
// Modports: slave = comp_seq side, master = producer/consumer side.
interface comp_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/comp_seq.sv
// comp_seq -- sequences one word at a time through an external bit-serial
// two's complementer and returns the parallel result.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : asynchronous, active-low
//   bus        : comp_seq_if.slave (in_valid/in_ready/in_data,
//                out_valid/out_ready/out_data)
//   comp_x     : serial bit to the complementer, LSB first (0 outside SHIFT)
//   comp_reset : one-cycle state clear to the complementer (CLEAR only)
//   comp_y     : complementer output, combinational in comp_x
//   err        : sticky self-check mismatch flag
//
// Optional feature: define COMP_SEQ_CHECK_EN to compare the serial result
// against (~word + 1) on entry to DONE; otherwise err is tied to 0.
//
// state | meaning
// IDLE  | in_ready=1, waiting for in_valid
// CLEAR | comp_reset=1 for one cycle, bit counter cleared
// SHIFT | WIDTH cycles of serial exchange, LSB first
// DONE  | out_valid=1, result held until out_ready
module comp_seq #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  comp_seq_if.slave   bus,
  output logic        comp_x,
  output logic        comp_reset,
  input  logic        comp_y,
  output logic        err
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             last_shift;
  logic [WIDTH-1:0] res_next;

  logic in_ready_w, out_valid_w, comp_x_w, comp_reset_w;

  assign last_shift = (cnt_q == CW'(WIDTH - 1));
  // comp_y lands at the MSB so the first (LSB) result bit ends up at bit 0.
  assign res_next   = {comp_y, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = CLEAR;
      CLEAR:   state_d = SHIFT;
      SHIFT:   if (last_shift) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    in_ready_w   = 1'b0;
    out_valid_w  = 1'b0;
    comp_x_w     = 1'b0;
    comp_reset_w = 1'b0;
    case (state_q)
      IDLE:    in_ready_w   = 1'b1;
      CLEAR:   comp_reset_w = 1'b1;
      SHIFT:   comp_x_w     = shift_q[0];
      DONE:    out_valid_w  = 1'b1;
      default: ;
    endcase
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = res_q;
  assign comp_x        = comp_x_w;
  assign comp_reset    = comp_reset_w;

  // Datapath: in_data is only sampled in IDLE, so later changes are ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE:  if (bus.in_valid) shift_q <= bus.in_data;
        CLEAR: cnt_q <= '0;
        SHIFT: begin
          shift_q <= shift_q >> 1;
          res_q   <= res_next;
          cnt_q   <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef COMP_SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic             err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.in_valid)
        exp_q <= ~bus.in_data + WIDTH'(1);
      // Evaluated on the edge that enters DONE, using the final shifted value.
      if (state_q == SHIFT && last_shift && (res_next != exp_q))
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_comp_seq.sv
module tb_comp_seq;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic comp_x, comp_reset, comp_y, err;

  always #5 clk = ~clk;

  comp_seq_if #(.WIDTH(W)) bus ();

  comp_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .bus        (bus.slave),
    .comp_x     (comp_x),
    .comp_reset (comp_reset),
    .comp_y     (comp_y),
    .err        (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // External serial complementer: passes bits up to and including the first
  // 1, inverts afterwards; cleared by comp_reset unless no_clear is set.
  logic seen_one = 1'b0;
  logic no_clear = 1'b0;
  assign comp_y = comp_x ^ seen_one;
  always @(posedge clk) begin
    if (comp_reset && !no_clear) seen_one <= 1'b0;
    else if (comp_x)             seen_one <= 1'b1;
  end

  // Reference model: one word in flight, timed by age since acceptance.
  // age 0 = clear cycle, 1..W = serial bit age-1, W+1 = result offered.
  logic         m_busy = 1'b0;
  int           m_age = 0;
  logic [W-1:0] m_word = '0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_age  <= 0;
    end else if (!m_busy) begin
      if (bus.in_valid) begin
        m_busy <= 1'b1;
        m_age  <= 0;
        m_word <= bus.in_data;
      end
    end else if (m_age < W + 1) begin
      m_age <= m_age + 1;
    end else if (bus.out_ready) begin
      m_busy <= 1'b0;
    end
  end

  logic chk_en = 1'b0, chk_data = 1'b1, chk_err = 1'b1;

  always @(negedge clk) begin
    int e_cx, e_res;
    if (rst_n && chk_en) begin
      e_cx = 0;
      if (m_busy && m_age >= 1 && m_age <= W) e_cx = int'(m_word[m_age-1]);
      e_res = (256 - int'(m_word)) % 256;
      chk("in_ready", int'(bus.in_ready), int'(!m_busy));
      chk("out_valid", int'(bus.out_valid), int'(m_busy && m_age == W + 1));
      chk("comp_reset", int'(comp_reset), int'(m_busy && m_age == 0));
      chk("comp_x", int'(comp_x), e_cx);
      if (chk_data && m_busy && m_age == W + 1)
        chk("out_data", int'(bus.out_data), e_res);
      if (chk_err) chk("err", int'(err), 0);
    end
  end

  int cyc = 0, creset_cnt = 0, done_cnt = 0, ov_cnt = 0;
  int acc_q[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n) begin
      if (comp_reset) creset_cnt <= creset_cnt + 1;
      if (bus.out_valid) ov_cnt <= ov_cnt + 1;
      if (bus.out_valid && bus.out_ready) done_cnt <= done_cnt + 1;
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
    end
  end

  // Latency counts the acceptance edge as clock 1.
  task automatic send_word(input logic [W-1:0] w, input int hold,
                           output logic [W-1:0] got, output int lat);
    int t;
    logic [W-1:0] first;
    t = 0;
    @(negedge clk);
    while (!bus.in_ready && t < 50) begin @(negedge clk); t++; end
    chk("in_ready_wait", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = W'($urandom);
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      bus.in_data = W'($urandom);
    end
    chk("out_valid_wait", int'(bus.out_valid), 1);
    got   = bus.out_data;
    first = bus.out_data;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_data", int'(bus.out_data), int'(first));
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] got;
    int lat, a0, c0, d0, o0, n;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_data", int'(bus.out_data), 0);
    chk("rst_comp_x", int'(comp_x), 0);
    chk("rst_comp_reset", int'(comp_reset), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(bus.in_ready), 1);
    chk_en = 1'b1;

    send_word(8'h0C, 0, got, lat);
    chk("0C_data", int'(got), 'hF4);
    chk("0C_latency", lat, 10);
    chk("0C_err", int'(err), 0);
    send_word(8'h00, 0, got, lat);
    chk("00_data", int'(got), 'h00);
    send_word(8'h01, 0, got, lat);
    chk("01_data", int'(got), 'hFF);
    send_word(8'h80, 0, got, lat);
    chk("80_data", int'(got), 'h80);
    send_word(8'h5A, 5, got, lat);
    chk("5A_data", int'(got), 'hA6);

    // Back-to-back: words accepted every W+3 cycles
    a0 = acc_q.size(); c0 = creset_cnt; d0 = done_cnt;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    repeat (60) begin
      bus.in_data = W'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    repeat (15) @(negedge clk);
    bus.out_ready = 1'b0;
    n = acc_q.size() - a0;
    chk("b2b_accepts", n, 6);
    for (int i = a0 + 1; i < acc_q.size(); i++)
      chk("b2b_spacing", acc_q[i] - acc_q[i-1], 11);
    chk("b2b_clear_pulses", creset_cnt - c0, n);
    chk("b2b_done", done_cnt - d0, n);

    // Reset after the third serial bit of 0x0C aborts the word
    @(negedge clk);
    o0 = ov_cnt;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h0C;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", int'(bus.out_valid), 0);
    chk("abort_comp_x", int'(comp_x), 0);
    chk("abort_out_data", int'(bus.out_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_no_output", ov_cnt - o0, 0);
    send_word(8'h01, 0, got, lat);
    chk("after_abort_data", int'(got), 'hFF);

    // Randomized traffic against the model
    repeat (1500) begin
      @(negedge clk);
      bus.in_valid  = ($urandom_range(0, 2) != 0);
      bus.in_data   = W'($urandom);
      bus.out_ready = $urandom_range(0, 1) == 1;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    bus.out_ready = 1'b0;
    chk("drain_idle", int'(bus.in_ready), 1);

`ifdef COMP_SEQ_CHECK_EN
    send_word(8'h02, 0, got, lat);
    chk("chk_first_02", int'(got), 'hFE);
    chk("chk_first_err", int'(err), 0);
    chk_data = 1'b0;
    chk_err = 1'b0;
    no_clear = 1'b1;
    send_word(8'h02, 0, got, lat);
    chk("chk_second_02", int'(got), 'hFD);
    chk("chk_err_set", int'(err), 1);
    no_clear = 1'b0;
    chk_data = 1'b1;
    send_word(8'h0C, 0, got, lat);
    chk("chk_recover_data", int'(got), 'hF4);
    chk("chk_err_sticky", int'(err), 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("chk_err_cleared", int'(err), 0);
    rst_n = 1'b1;
    chk_err = 1'b1;
    repeat (2) @(negedge clk);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/comp_seq.md
COMP_SEQ -- requirements
Module: comp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the word length in bits; legal range is 2 to 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 The block SHALL have port in_data, input, WIDTH bits: the word to complement.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the result word is valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: the two's complement of the accepted word.
REQ-010 The block SHALL have port comp_x, output, 1 bit: the serial bit driven to the external serial complementer, LSB first.
REQ-011 The block SHALL have port comp_reset, output, 1 bit: the active-high state clear driven to the external complementer.
REQ-012 The block SHALL have port comp_y, input, 1 bit: the complementer output, a combinational function of comp_x and the complementer's state.
REQ-013 The block SHALL have port err, output, 1 bit: sticky self-check mismatch flag.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, CLEAR, SHIFT and DONE.
REQ-015 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-016 When in IDLE with in_valid=1 at a clock edge, the FSM SHALL capture in_data into the shift register and go to CLEAR.
REQ-017 In CLEAR, comp_reset SHALL be 1 for exactly one cycle, the bit counter SHALL be cleared to 0, and the FSM SHALL then go to SHIFT.
REQ-018 In SHIFT, each cycle SHALL drive comp_x from shift register bit 0.
REQ-019 In SHIFT, each clock edge SHALL shift comp_y into the result register from the MSB side (shift right), shift the input register right, and increment the counter.
REQ-020 After WIDTH SHIFT cycles, the FSM SHALL go to DONE.
REQ-021 In DONE, out_valid SHALL be 1 and out_data SHALL hold the result stably.
REQ-022 In DONE, a clock edge with out_ready=1 SHALL return the FSM to IDLE; out_ready=0 SHALL hold DONE indefinitely.
REQ-023 Latency SHALL be fixed: out_valid is asserted WIDTH+2 clocks after the acceptance edge, so one word is in flight at a time.
REQ-024 A DONE-to-IDLE transition and a new acceptance SHALL NOT occur on the same edge; the minimum input spacing is WIDTH+3 cycles.
REQ-025 comp_x SHALL be 0 and comp_reset SHALL be 0 outside SHIFT and CLEAR respectively.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH: 0 maps to 0, and the most negative value (1 followed by zeros) maps to itself.
REQ-027 in_data changes while not in IDLE SHALL be ignored.

Reset
REQ-028 Asserting reset low SHALL immediately force IDLE, clear the shift, result and counter registers, and drive out_valid=0, out_data=0, comp_x=0, comp_reset=0 and err=0; in_ready SHALL be 1 once reset is released.
REQ-029 Reset mid-SHIFT SHALL abort the word without emitting any output; the next accepted word SHALL still pass through CLEAR.

Configuration
REQ-030 When macro COMP_SEQ_CHECK_EN is defined, the block SHALL compute (~word + 1) mod 2^WIDTH at acceptance.
REQ-031 With COMP_SEQ_CHECK_EN defined, on entry to DONE the block SHALL set err to 1 if the serial result differs from that value; err SHALL stay 1 until reset.
REQ-032 When COMP_SEQ_CHECK_EN is undefined, err SHALL be tied to 0 and the check logic SHALL be absent.

Verification (WIDTH=8, bench models the complementer: pass bits through up to and including the first 1, invert afterwards, cleared by comp_reset)
REQ-033 A bench SHALL cover: in_data 0x0C -> out_data 0xF4, out_valid 10 clocks after acceptance, err=0.
REQ-034 A bench SHALL cover: 0x00 -> 0x00; 0x01 -> 0xFF; 0x80 -> 0x80.
REQ-035 A bench SHALL cover: back-to-back in_valid=1 with out_ready=1 -> in_ready=1 only in IDLE, words complete every 11 cycles, and comp_reset pulses once per word.
REQ-036 A bench SHALL cover: out_ready held 0 for 5 cycles in DONE -> out_data stable and in_ready=0 throughout.
REQ-037 A bench SHALL cover: reset pulsed after the 3rd SHIFT cycle of 0x0C, then 0x01 sent -> no output for 0x0C, then 0xFF.
REQ-038 A bench SHALL cover, with COMP_SEQ_CHECK_EN defined: the model forced to an unresetting state (comp_reset ignored) while sending 0x02 then 0x02 -> the second result is wrong and err=1, sticky until reset.
